// File: rtl/dpcm_pkg.sv
// ---------------------------------------------------------------------------
// dpcm_pkg
//   Types and arithmetic shared by the camera DPCM compressor and the
//   read-side decoder. Keeping prediction and delta expansion here means
//   the two ends cannot drift apart bit-wise.
//
//   rgb888_t     packed {R,G,B} pixel, 8 bits per channel
//   chan_vec_t   same pixel viewed as [NUM_CH][8]; index 2 = R, 0 = B
//   dpcm_code_t  16-bit code, {R[4:0], G[5:0], B[4:0]} two's complement
//   dec_state_e  decoder sequencing states
//   dpcm_pred    (l + u) >> 1 with a 9-bit intermediate
//   dpcm_delta   expands each code field to its 8-bit scaled residual
// ---------------------------------------------------------------------------
package dpcm_pkg;

    localparam int         NUM_CH          = 3;
    localparam int         SHIFT_R         = 3;
    localparam int         SHIFT_G         = 2;
    localparam int         SHIFT_B         = 3;
    localparam logic [7:0] BORDER_PRED_DEF = 8'h7F;

    typedef logic [23:0]              rgb888_t;
    typedef logic [NUM_CH-1:0][7:0]   chan_vec_t;

    typedef struct packed {
        logic signed [4:0] r;
        logic signed [5:0] g;
        logic signed [4:0] b;
    } dpcm_code_t;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2
    } dec_state_e;

    function automatic logic [7:0] dpcm_pred(input logic [7:0] l, input logic [7:0] u);
        logic [8:0] sum;
        sum = {1'b0, l} + {1'b0, u};
        return sum[8:1];
    endfunction

    // Field width plus shift is exactly 8 for every channel, so appending
    // zeros gives sext(field) << shift already reduced modulo 256.
    function automatic chan_vec_t dpcm_delta(input dpcm_code_t c);
        chan_vec_t d;
        d[2] = {c.r, {SHIFT_R{1'b0}}};
        d[1] = {c.g, {SHIFT_G{1'b0}}};
        d[0] = {c.b, {SHIFT_B{1'b0}}};
        return d;
    endfunction

endpackage

// File: rtl/dpcm_rgb_decoder_if.sv
// ---------------------------------------------------------------------------
// dpcm_rgb_decoder_if
//   Code stream in (valid/ready + sof), pixel stream out (valid/ready +
//   sof/eol), and the resync error pulse.
//   slave  : the decoder
//   master : the surrounding fabric (SDRAM read FIFO + VGA pixel path)
// ---------------------------------------------------------------------------
interface dpcm_rgb_decoder_if;
    import dpcm_pkg::*;

    logic        i_valid;
    logic        i_sof;
    logic [15:0] i_code;
    logic        o_ready;
    logic        o_valid;
    logic        o_sof;
    logic        o_eol;
    rgb888_t     o_rgb;
    logic        i_out_ready;
    logic        o_sync_err;

    modport slave (
        input  i_valid, i_sof, i_code, i_out_ready,
        output o_ready, o_valid, o_sof, o_eol, o_rgb, o_sync_err
    );

    modport master (
        output i_valid, i_sof, i_code, i_out_ready,
        input  o_ready, o_valid, o_sof, o_eol, o_rgb, o_sync_err
    );

endinterface

// File: rtl/dpcm_line_buffer.sv
// ---------------------------------------------------------------------------
// dpcm_line_buffer
//   One line of reconstructed pixels: 1 write port, 1 registered read port.
//   Contents are not reset; the decoder never uses them on row 0.
//   o_rdata only updates when i_re is high, so it holds across stalls.
//
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address (column)
//   i_wdata  write data
//   i_re     read enable
//   i_raddr  read address (column)
//   o_rdata  read data, one cycle after i_re
// ---------------------------------------------------------------------------
module dpcm_line_buffer #(
    parameter int DEPTH = 800,
    parameter int WIDTH = 24,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        if (i_re) rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dpcm_rgb_decoder.sv
// ---------------------------------------------------------------------------
// dpcm_rgb_decoder
//   Rebuilds RGB888 from 16-bit DPCM codes, bit-exact with the camera
//   compressor. Left neighbour lives in a register, up neighbour in a
//   one-line RAM that is read one column ahead so its output lines up with
//   the next accepted code. One output register: 1 pixel/clk, latency 1.
//
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   bus.i_valid      code beat valid
//   bus.i_sof        beat is first pixel of a frame
//   bus.i_code       {R[15:11], G[10:5], B[4:0]} two's complement residuals
//   bus.o_ready      code accepted this cycle when i_valid
//   bus.o_valid      decoded pixel valid
//   bus.o_sof        pixel is (row 0, col 0)
//   bus.o_eol        pixel is last column
//   bus.o_rgb        {R,G,B} reconstructed
//   bus.i_out_ready  downstream accepts pixel
//   bus.o_sync_err   1-cycle pulse: sof seen away from (0,0)
// ---------------------------------------------------------------------------
module dpcm_rgb_decoder
    import dpcm_pkg::*;
#(
    parameter int         H_ACTIVE    = 800,
    parameter int         V_ACTIVE    = 600,
    parameter logic [7:0] BORDER_PRED = BORDER_PRED_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    dpcm_rgb_decoder_if.slave bus
);

    localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    dec_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    chan_vec_t     left_q;
    logic          o_valid_q, o_sof_q, o_eol_q;
    rgb888_t       o_rgb_q;

    logic          ready;
    logic          dec_fire;
    logic          out_fire;
    logic          resync;
    logic          at_origin;
    logic          last_col;
    logic          last_row;

    dpcm_code_t    code;
    chan_vec_t     delta;
    chan_vec_t     l_ch;
    chan_vec_t     u_ch;
    chan_vec_t     rec;
    chan_vec_t     lb_rdata;
    logic          lb_re;
    logic [CW-1:0] lb_raddr;

    assign at_origin = (row_q == '0) && (col_q == '0);
    assign last_col  = (col_q == CW'(H_ACTIVE - 1));
    assign last_row  = (row_q == RW'(V_ACTIVE - 1));

    // A sof beat away from the origin is held off; counters snap to (0,0)
    // and the beat is taken again after the re-prime cycle.
    assign resync    = (state_q == ST_RUN) && bus.i_valid && bus.i_sof && !at_origin;

    assign dec_fire  = (state_q == ST_RUN) && bus.i_valid && ready;
    assign out_fire  = o_valid_q && bus.i_out_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_WAIT_SOF;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                // Non-sof beats are swallowed; the sof beat itself waits.
                ready = !(bus.i_valid && bus.i_sof);
                if (bus.i_valid && bus.i_sof) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                ready = (!o_valid_q || bus.i_out_ready) && !resync;
                if (resync) state_d = ST_PRIME;
            end
            default: state_d = ST_WAIT_SOF;
        endcase
    end

    // ---------------- position counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (resync) begin
            col_d = '0;
            row_d = '0;
        end else if (dec_fire) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- line buffer ----------------
    // Read one column ahead; at end of line wrap to column 0, which was
    // written earlier in the current line and is the next row's up pixel.
    always_comb begin
        lb_re    = dec_fire || (state_q == ST_PRIME);
        lb_raddr = '0;
        if (state_q != ST_PRIME && !last_col) lb_raddr = col_q + CW'(1);
    end

    dpcm_line_buffer #(
        .DEPTH (H_ACTIVE),
        .WIDTH (24),
        .AW    (CW)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .i_we    (dec_fire),
        .i_waddr (col_q),
        .i_wdata (rec),
        .i_re    (lb_re),
        .i_raddr (lb_raddr),
        .o_rdata (lb_rdata)
    );

    // ---------------- prediction / reconstruction ----------------
    assign code  = dpcm_code_t'(bus.i_code);
    assign delta = dpcm_delta(code);

    // Modulo-256 add, no saturation: the encoder wraps the same way.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign l_ch[ch] = (col_q == '0) ? BORDER_PRED : left_q[ch];
        assign u_ch[ch] = (row_q == '0) ? BORDER_PRED : lb_rdata[ch];
        assign rec[ch]  = dpcm_pred(l_ch[ch], u_ch[ch]) + delta[ch];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) left_q <= '0;
        else if (dec_fire) left_q <= rec;
    end

    // ---------------- output register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_sof_q   <= 1'b0;
            o_eol_q   <= 1'b0;
            o_rgb_q   <= '0;
        end else if (dec_fire) begin
            o_valid_q <= 1'b1;
            o_sof_q   <= at_origin;
            o_eol_q   <= last_col;
            o_rgb_q   <= rec;
        end else if (out_fire) begin
            o_valid_q <= 1'b0;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = o_valid_q;
    assign bus.o_sof      = o_sof_q;
    assign bus.o_eol      = o_eol_q;
    assign bus.o_rgb      = o_rgb_q;
    assign bus.o_sync_err = resync;

endmodule

// File: tb/tb_dpcm_rgb_decoder.sv
module tb_dpcm_rgb_decoder;

    localparam int H = 16;
    localparam int V = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dpcm_rgb_decoder_if bus();

    dpcm_rgb_decoder #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .BORDER_PRED (8'h7F)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        expq[$];
    logic [23:0] img [V][H];
    int          mrow, mcol;
    bit          mwait;
    logic [23:0] last_exp;

    int checks = 0;
    int passes = 0;
    int sof_cnt, eol_cnt;
    bit rand_mode = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    endtask

    // ---------------- reference model: image array + neighbour rule ----------------
    function automatic logic [23:0] model_pix(input int r, input int c, input logic [15:0] code);
        logic [23:0] res;
        int lv, uv, p, f, d;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (c == 0) lv = 127; else lv = int'(img[r][c-1][23-8*ch -: 8]);
            if (r == 0) uv = 127; else uv = int'(img[r-1][c][23-8*ch -: 8]);
            p = (lv + uv) / 2;
            if (ch == 0)      begin f = int'(code[15:11]); if (f > 15) f -= 32; d = f * 8; end
            else if (ch == 1) begin f = int'(code[10:5]);  if (f > 31) f -= 64; d = f * 4; end
            else              begin f = int'(code[4:0]);   if (f > 15) f -= 32; d = f * 8; end
            res[23-8*ch -: 8] = 8'((p + d) & 255);
        end
        return res;
    endfunction

    function automatic void model_accept(input logic [15:0] code, input logic sof, input bit rs);
        logic [23:0] px;
        if (mwait) begin
            if (!sof) return;
            mwait = 0;
        end
        if (rs) begin mrow = 0; mcol = 0; end
        px = model_pix(mrow, mcol, code);
        img[mrow][mcol] = px;
        last_exp = px;
        expq.push_back('{rgb: px, sof: (mrow == 0 && mcol == 0), eol: (mcol == H - 1)});
        if (mcol == H - 1) begin
            mcol = 0;
            mrow = (mrow == V - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endfunction

    // ---------------- downstream ready ----------------
    initial forever begin
        @(posedge clk);
        #2;
        bus.i_out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- compare process ----------------
    initial begin : monitor
        bit          stab_pend;
        logic [23:0] stab_rgb;
        exp_t        e;
        stab_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stab_pend = 0;
            end else begin
                if (stab_pend) begin
                    chk("hold_valid", 32'(bus.o_valid), 32'd1);
                    chk("hold_rgb", 32'(bus.o_rgb), 32'(stab_rgb));
                end
                stab_pend = bus.o_valid && !bus.i_out_ready;
                stab_rgb  = bus.o_rgb;
                if (bus.o_valid && bus.i_out_ready) begin
                    if (bus.o_sof) sof_cnt++;
                    if (bus.o_eol) eol_cnt++;
                    if (expq.size() == 0) begin
                        chk("unexpected_pixel", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("pix_rgb", 32'(bus.o_rgb), 32'(e.rgb));
                        chk("pix_sof", 32'(bus.o_sof), 32'(e.sof));
                        chk("pix_eol", 32'(bus.o_eol), 32'(e.eol));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] code, input logic sof, output int stalls);
        bit rs, ok;
        int n;
        rs = !mwait && sof && !(mrow == 0 && mcol == 0);
        bus.i_valid = 1'b1;
        bus.i_sof   = sof;
        bus.i_code  = code;
        n  = 0;
        ok = 0;
        while (!ok && n <= 40) begin
            @(negedge clk);
            chk("sync_err", 32'(bus.o_sync_err), 32'((n == 0) && rs));
            if (bus.o_ready) ok = 1;
            else n++;
            @(posedge clk);
        end
        #1;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        stalls = n;
        if (ok) model_accept(code, sof, rs);
        else    chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_code  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_sof", 32'(bus.o_sof), 32'd0);
        chk("rst_eol", 32'(bus.o_eol), 32'd0);
        chk("rst_rgb", 32'(bus.o_rgb), 32'd0);
        chk("rst_sync_err", 32'(bus.o_sync_err), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        expq.delete();
        mwait = 1; mrow = 0; mcol = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin tick(); n++; end
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_code  = '0;
        do_reset();
        tick();

        // sof beat with zero residual: pure border prediction
        send(16'h0000, 1'b1, st);
        chk("t1_prime_stalls", 32'(st), 32'd2);
        @(negedge clk);
        chk("t1_valid", 32'(bus.o_valid), 32'd1);
        chk("t1_rgb", 32'(bus.o_rgb), 32'h7F7F7F);
        chk("t1_sof", 32'(bus.o_sof), 32'd1);
        tick();

        // R=+1, G=-1 residuals, then left-neighbour prediction
        do_reset();
        tick();
        send(16'h0FE0, 1'b1, st);
        chk("t2_model_pin0", 32'(last_exp), 32'h877B7F);
        @(negedge clk);
        chk("t2_rgb0", 32'(bus.o_rgb), 32'h877B7F);
        tick();
        send(16'h0000, 1'b0, st);
        chk("t2_model_pin1", 32'(last_exp), 32'h837D7F);
        @(negedge clk);
        chk("t2_rgb1", 32'(bus.o_rgb), 32'h837D7F);
        tick();
        drain();

        // full frame, random residuals, full throughput
        do_reset();
        tick();
        sof_cnt = 0;
        eol_cnt = 0;
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                send(16'($urandom()), 1'b1 && (r == 0 && c == 0), st);
        drain();
        chk("t3_eol_count", 32'(eol_cnt), 32'(V));
        chk("t3_sof_count", 32'(sof_cnt), 32'd1);

        // two lines under random backpressure; sof at origin is a normal beat
        rand_mode = 1;
        for (int i = 0; i < 2 * H; i++)
            send(16'($urandom()), 1'b1 && (i == 0), st);
        rand_mode = 0;
        tick(); tick();
        drain();

        // walk to (3,5) and raise sof there
        for (int i = 0; i < H + 5; i++)
            send(16'($urandom()), 1'b0, st);
        send(16'h0000, 1'b1, st);
        chk("t5_resync_stalls", 32'(st), 32'd2);
        @(negedge clk);
        chk("t5_sof", 32'(bus.o_sof), 32'd1);
        chk("t5_rgb", 32'(bus.o_rgb), 32'h7F7F7F);
        tick();
        for (int i = 0; i < 5; i++)
            send(16'($urandom()), 1'b0, st);

        // reset with a pixel pending, then codes before sof are dropped
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            send(16'($urandom()), 1'b0, st);
            chk("t6_drop_ready", 32'(st), 32'd0);
        end
        @(negedge clk);
        chk("t6_no_output", 32'(bus.o_valid), 32'd0);
        tick();
        send(16'h0FE0, 1'b1, st);
        chk("t6_prime_stalls", 32'(st), 32'd2);
        @(negedge clk);
        chk("t6_rgb", 32'(bus.o_rgb), 32'h877B7F);
        tick();
        for (int i = 0; i < 4; i++)
            send(16'($urandom()), 1'b0, st);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
